// File: rtl/spram_fifo_ctrl.sv
// FIFO controller around an external sync-read single-port RAM (one RAM op per cycle).
// Optional macro SPRAM_FIFO_WR_PRIO_EN gives writes priority over reads; default is read priority.
module spram_fifo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int RAM_DEPTH  = 32
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iS_Valid,
  input  logic [DATA_WIDTH-1:0] iS_Data,
  output logic                  oS_Ready,
  output logic                  oM_Valid,
  output logic [DATA_WIDTH-1:0] oM_Data,
  input  logic                  iM_Ready,
  output logic                  oRam_R_EN,
  output logic                  oRam_W_EN,
  output logic [ADDR_WIDTH-1:0] oRam_Addr,
  output logic [DATA_WIDTH-1:0] oRam_Data,
  input  logic [DATA_WIDTH-1:0] iRam_Data,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oFull,
  output logic                  oEmpty
);

  // Both ports transfer on the rising edge where valid && ready; valid never waits on ready.

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  out_vld;

  logic not_full;
  logic not_empty;
  logic rd_req;
  logic wr_req;
  logic rd_go;
  logic wr_go;

  assign not_full  = (cnt != DEPTH_C);
  assign not_empty = (cnt != '0);
  assign rd_req    = not_empty && (!out_vld || iM_Ready);
  assign wr_req    = iS_Valid && not_full;

`ifdef SPRAM_FIFO_WR_PRIO_EN
  assign wr_go    = wr_req;
  assign rd_go    = rd_req && !wr_req;
  assign oS_Ready = not_full;
`else
  assign rd_go    = rd_req;
  assign wr_go    = wr_req && !rd_req;
  assign oS_Ready = not_full && !rd_go;
`endif

  assign oRam_R_EN = rd_go;
  assign oRam_W_EN = wr_go;
  assign oRam_Addr = rd_go ? rd_ptr : wr_ptr;
  assign oRam_Data = iS_Data;

  // The RAM keeps its last read word while R_EN is low, so the output stage needs no register.
  assign oM_Data  = iRam_Data;
  assign oM_Valid = out_vld;
  assign oCount   = cnt;
  assign oFull    = (cnt == DEPTH_C);
  assign oEmpty   = !not_empty && !out_vld;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      out_vld <= 1'b0;
    end else begin
      if (wr_go) begin
        wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_go) begin
        rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_go, rd_go})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (rd_go) begin
        out_vld <= 1'b1;
      end else if (iM_Ready) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule
